// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns EX/MEM load/store requests into a req/ack
// handshake with a multi-cycle memory, stalling the pipeline until the access retires.
module dmem_access_ctrl #(
    parameter int N       = 64,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         memRead_actual,
    input  logic         memWrite_actual,
    input  logic [N-1:0] ALUResult_actual,
    input  logic [N-1:0] writeDataMem_actual,
    input  logic         mem_ack,
    input  logic [N-1:0] mem_rdata,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    output logic         stall,
    output logic [N-1:0] rdata_out,
    output logic         err_misalign,
    output logic         err_timeout
);

    localparam int OFF_W = $clog2(N / 8);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               req_d, we_d, tmo_d;
    logic [N-1:0]       addr_d, wdata_d, rdata_d;
    logic               stall_c, misalign_c;
    logic               access, misaligned;

    assign access     = memRead_actual | memWrite_actual;
    assign misaligned = |ALUResult_actual[OFF_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata_out   <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            mem_req     <= req_d;
            mem_we      <= we_d;
            mem_addr    <= addr_d;
            mem_wdata   <= wdata_d;
            rdata_out   <= rdata_d;
            err_timeout <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        req_d      = mem_req;
        we_d       = mem_we;
        addr_d     = mem_addr;
        wdata_d    = mem_wdata;
        rdata_d    = rdata_out;
        tmo_d      = 1'b0;
        stall_c    = 1'b0;
        misalign_c = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        misalign_c = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        req_d   = 1'b1;
                        we_d    = memWrite_actual;
                        addr_d  = ALUResult_actual;
                        wdata_d = writeDataMem_actual;
                        cnt_d   = '0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                stall_c = 1'b1;
                // An ack arriving on the final wait cycle still counts as success.
                if (mem_ack) begin
                    req_d = 1'b0;
                    if (!mem_we) rdata_d = mem_rdata;
                    state_d = DONE;
                end else if (cnt == CNT_LAST) begin
                    req_d   = 1'b0;
                    rdata_d = '0;
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Combinational outputs are forced low while reset is held so the pipeline is released at once.
    assign stall        = stall_c & rst;
    assign err_misalign = misalign_c & rst;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed, table-driven bench for dmem_access_ctrl: per-cycle input/expected records
// plus hand-written timeout and asynchronous-reset sequences.
module tb_dmem_access_ctrl;

    localparam int N       = 64;
    localparam int TIMEOUT = 16;

    logic         clk;
    logic         rst;
    logic         memRead_actual;
    logic         memWrite_actual;
    logic [N-1:0] ALUResult_actual;
    logic [N-1:0] writeDataMem_actual;
    logic         mem_ack;
    logic [N-1:0] mem_rdata;
    logic         mem_req;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic         stall;
    logic [N-1:0] rdata_out;
    logic         err_misalign;
    logic         err_timeout;

    int total = 0;
    int bad   = 0;

    dmem_access_ctrl #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .memRead_actual      (memRead_actual),
        .memWrite_actual     (memWrite_actual),
        .ALUResult_actual    (ALUResult_actual),
        .writeDataMem_actual (writeDataMem_actual),
        .mem_ack             (mem_ack),
        .mem_rdata           (mem_rdata),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .stall               (stall),
        .rdata_out           (rdata_out),
        .err_misalign        (err_misalign),
        .err_timeout         (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per clock cycle: inputs held for the cycle, outputs expected before its closing edge.
    typedef struct {
        logic         rd, wr;
        logic [N-1:0] addr, wdata;
        logic         ack;
        logic [N-1:0] rdata;
        logic         req, we;
        logic [N-1:0] maddr, mwdata;
        logic         stall;
        logic [N-1:0] rdo;
        logic         mis, tmo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rd, logic wr, logic [N-1:0] addr, logic [N-1:0] wdata,
                                logic ack, logic [N-1:0] rdata,
                                logic req, logic we, logic [N-1:0] maddr, logic [N-1:0] mwdata,
                                logic stl, logic [N-1:0] rdo, logic mis, logic tmo);
        vec_t v;
        v.rd = rd;   v.wr = wr;   v.addr = addr;   v.wdata = wdata;
        v.ack = ack; v.rdata = rdata;
        v.req = req; v.we = we;   v.maddr = maddr; v.mwdata = mwdata;
        v.stall = stl; v.rdo = rdo; v.mis = mis;   v.tmo = tmo;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        memRead_actual      = v.rd;
        memWrite_actual     = v.wr;
        ALUResult_actual    = v.addr;
        writeDataMem_actual = v.wdata;
        mem_ack             = v.ack;
        mem_rdata           = v.rdata;
    endtask

    // Request attributes are only meaningful while a request is outstanding.
    task automatic checkOutput(input vec_t v, input string tag);
        cmp({tag, ".mem_req"},      N'(mem_req),      N'(v.req));
        cmp({tag, ".stall"},        N'(stall),        N'(v.stall));
        cmp({tag, ".rdata_out"},    rdata_out,        v.rdo);
        cmp({tag, ".err_misalign"}, N'(err_misalign), N'(v.mis));
        cmp({tag, ".err_timeout"},  N'(err_timeout),  N'(v.tmo));
        if (v.req) begin
            cmp({tag, ".mem_we"},    N'(mem_we), N'(v.we));
            cmp({tag, ".mem_addr"},  mem_addr,   v.maddr);
            cmp({tag, ".mem_wdata"}, mem_wdata,  v.mwdata);
        end
    endtask

    task automatic runVec(input vec_t v, input string tag);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        cmp({tag, ".mem_req"},      N'(mem_req),      '0);
        cmp({tag, ".mem_we"},       N'(mem_we),       '0);
        cmp({tag, ".mem_addr"},     mem_addr,         '0);
        cmp({tag, ".mem_wdata"},    mem_wdata,        '0);
        cmp({tag, ".stall"},        N'(stall),        '0);
        cmp({tag, ".rdata_out"},    rdata_out,        '0);
        cmp({tag, ".err_misalign"}, N'(err_misalign), '0);
        cmp({tag, ".err_timeout"},  N'(err_timeout),  '0);
    endtask

    initial begin
        // Same-cycle-ack load of 0x40 returning 0xDEAD
        tbl.push_back(mk(1,0,'h40,0,0,0,           0,0,0,0,         1,0,0,0));
        tbl.push_back(mk(1,0,'h40,0,1,'hDEAD,      1,0,'h40,0,      1,0,0,0));
        tbl.push_back(mk(1,0,'h40,0,0,0,           0,0,0,0,         0,'hDEAD,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,              0,0,0,0,         0,'hDEAD,0,0));
        // Store 0x1234 to 0x88, ack after three wait cycles; rdata on ack must be ignored
        tbl.push_back(mk(0,1,'h88,'h1234,0,0,      0,0,0,0,         1,'hDEAD,0,0));
        tbl.push_back(mk(0,1,'h88,'h1234,0,0,      1,1,'h88,'h1234, 1,'hDEAD,0,0));
        tbl.push_back(mk(0,1,'h88,'h1234,0,0,      1,1,'h88,'h1234, 1,'hDEAD,0,0));
        tbl.push_back(mk(0,1,'h88,'h1234,0,0,      1,1,'h88,'h1234, 1,'hDEAD,0,0));
        tbl.push_back(mk(0,1,'h88,'h1234,1,'hBAD,  1,1,'h88,'h1234, 1,'hDEAD,0,0));
        tbl.push_back(mk(0,1,'h88,'h1234,0,0,      0,0,0,0,         0,'hDEAD,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,              0,0,0,0,         0,'hDEAD,0,0));
        // Misaligned load of 0x43
        tbl.push_back(mk(1,0,'h43,0,0,0,           0,0,0,0,         0,'hDEAD,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,              0,0,0,0,         0,'hDEAD,0,0));
        // Read and write both set: behaves as a store
        tbl.push_back(mk(1,1,'h20,'h55,0,0,        0,0,0,0,         1,'hDEAD,0,0));
        tbl.push_back(mk(1,1,'h20,'h55,1,'h777,    1,1,'h20,'h55,   1,'hDEAD,0,0));
        tbl.push_back(mk(1,1,'h20,'h55,0,0,        0,0,0,0,         0,'hDEAD,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,              0,0,0,0,         0,'hDEAD,0,0));
        // Back-to-back loads 0x10 then 0x18
        tbl.push_back(mk(1,0,'h10,0,0,0,           0,0,0,0,         1,'hDEAD,0,0));
        tbl.push_back(mk(1,0,'h10,0,1,'h1111,      1,0,'h10,0,      1,'hDEAD,0,0));
        tbl.push_back(mk(1,0,'h10,0,0,0,           0,0,0,0,         0,'h1111,0,0));
        tbl.push_back(mk(1,0,'h18,0,0,0,           0,0,0,0,         1,'h1111,0,0));
        tbl.push_back(mk(1,0,'h18,0,0,0,           1,0,'h18,0,      1,'h1111,0,0));
        tbl.push_back(mk(1,0,'h18,0,1,'h2222,      1,0,'h18,0,      1,'h1111,0,0));
        tbl.push_back(mk(1,0,'h18,0,0,0,           0,0,0,0,         0,'h2222,0,0));
        // Stray ack while idle is ignored
        tbl.push_back(mk(0,0,0,0,1,'h9999,         0,0,0,0,         0,'h2222,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,              0,0,0,0,         0,'h2222,0,0));

        rst = 1'b0;
        applyStimulus(mk(0,0,0,0,0,0, 0,0,0,0, 0,0,0,0));
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        foreach (tbl[i]) runVec(tbl[i], $sformatf("v%0d", i));

        // Load that is never acknowledged: 16 request cycles, then abort
        runVec(mk(1,0,'h80,0,0,0, 0,0,0,0, 1,'h2222,0,0), "tmo_idle");
        for (int i = 0; i < TIMEOUT; i++)
            runVec(mk(1,0,'h80,0,0,0, 1,0,'h80,0, 1,'h2222,0,0), $sformatf("tmo_acc%0d", i));
        runVec(mk(1,0,'h80,0,1,'hFFFF, 0,0,0,0, 0,0,0,1), "tmo_done");
        runVec(mk(0,0,0,0,0,0, 0,0,0,0, 0,0,0,0), "tmo_after");

        // Load 0xABCD so rdata_out is nonzero, then reset in the middle of the next access
        runVec(mk(1,0,'h30,0,0,0,       0,0,0,0,    1,0,0,0),       "rl_idle");
        runVec(mk(1,0,'h30,0,1,'hABCD,  1,0,'h30,0, 1,0,0,0),       "rl_acc");
        runVec(mk(1,0,'h30,0,0,0,       0,0,0,0,    0,'hABCD,0,0),  "rl_done");
        runVec(mk(1,0,'h38,0,0,0,       0,0,0,0,    1,'hABCD,0,0),  "rs_idle");
        runVec(mk(1,0,'h38,0,0,0,       1,0,'h38,0, 1,'hABCD,0,0),  "rs_acc");
        #1;
        rst = 1'b0;
        #1;
        checkAllZero("rst_async");
        @(posedge clk);
        @(negedge clk);
        checkAllZero("rst_held");
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(mk(0,0,0,0,0,0, 0,0,0,0, 0,0,0,0));
        @(negedge clk);
        checkAllZero("rst_release");
        @(posedge clk);
        #1;

        runVec(mk(1,0,'h48,0,0,0,       0,0,0,0,    1,0,0,0),       "pr_idle");
        runVec(mk(1,0,'h48,0,1,'h5A5A,  1,0,'h48,0, 1,0,0,0),       "pr_acc");
        runVec(mk(1,0,'h48,0,0,0,       0,0,0,0,    0,'h5A5A,0,0),  "pr_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
